// File: rtl/maria_video_rx_if.sv
// ============================================================================
//  Module      : maria_video_rx_if
//  Description : Video input, line-buffer read port and status bundle for
//                maria_video_rx. Optional frame_crc member is present when
//                MARIA_VRX_CRC_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface maria_video_rx_if;
  // Video stream from the Maria core
  logic       mclk0;
  logic [7:0] YC;
  logic       hsync;
  logic       vsync;
  logic       hblank;
  logic       vblank;
  // Random-access read port into the completed line
  logic [8:0] rd_addr;
  logic [7:0] rd_data;
  // Line / frame status
  logic       rd_bank;
  logic       line_ready;
  logic [8:0] line_num;
  logic [8:0] line_len;
  logic       frame_start;
  logic       pal_detect;
  logic       overflow;
`ifdef MARIA_VRX_CRC_EN
  logic [15:0] frame_crc;
`endif

`ifdef MARIA_VRX_CRC_EN
  // Video source and downstream reader side
  modport master (
    output mclk0, YC, hsync, vsync, hblank, vblank, rd_addr,
    input  rd_data, rd_bank, line_ready, line_num, line_len,
    input  frame_start, pal_detect, overflow, frame_crc
  );
  // Receiver side
  modport slave (
    input  mclk0, YC, hsync, vsync, hblank, vblank, rd_addr,
    output rd_data, rd_bank, line_ready, line_num, line_len,
    output frame_start, pal_detect, overflow, frame_crc
  );
`else
  // Video source and downstream reader side
  modport master (
    output mclk0, YC, hsync, vsync, hblank, vblank, rd_addr,
    input  rd_data, rd_bank, line_ready, line_num, line_len,
    input  frame_start, pal_detect, overflow
  );
  // Receiver side
  modport slave (
    input  mclk0, YC, hsync, vsync, hblank, vblank, rd_addr,
    output rd_data, rd_bank, line_ready, line_num, line_len,
    output frame_start, pal_detect, overflow
  );
`endif
endinterface

`default_nettype wire

// File: rtl/maria_video_rx.sv
// ============================================================================
//  Module      : maria_video_rx
//  Description : Maria video receiver. Captures YC on each mclk0 pixel enable
//                during active video into a ping-pong line buffer, tracks
//                line/frame position and exposes the completed line through a
//                registered read port. Optional per-frame CRC-16-CCITT over all
//                written pixels when MARIA_VRX_CRC_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module maria_video_rx #(
  parameter int MAX_PIX    = 320,
  parameter int PAL_THRESH = 288
) (
  input  wire logic        clk_sys,
  input  wire logic        reset,
  maria_video_rx_if.slave  bus
);

  localparam int DEPTH = 2 * MAX_PIX;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t     state;
  state_t     state_next;

  // Both banks share one array: bank 0 at [0, MAX_PIX), bank 1 above it
  logic [7:0] mem [DEPTH];

  logic       hblank_q;
  logic       vsync_q;
  logic       hblank_rise;
  logic       vsync_rise;

  logic [8:0] wr_ptr;
  logic [8:0] vis_line;
  logic [8:0] line_cnt;
  logic [8:0] line_cnt_next;
  logic       seen_vsync;

  logic       rd_bank;
  logic       line_ready;
  logic [8:0] line_num;
  logic [8:0] line_len;
  logic       frame_start;
  logic       pal_detect;
  logic       overflow;
  logic [7:0] rd_data;

  logic       pix_ok;
  logic       pix_we;
  logic       line_end;
  logic       line_done;
  logic       store;
  logic       pix_over;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_idx;
  logic          rd_in_range;

  // Edge detection runs every clk_sys, independent of the pixel enable
  assign hblank_rise = bus.hblank & ~hblank_q;
  assign vsync_rise  = bus.vsync  & ~vsync_q;

  // A pixel only counts outside both blanking intervals
  assign pix_ok = bus.mclk0 & ~bus.hblank & ~bus.vblank;

  // Pixels past MAX_PIX are dropped and flag overflow instead
  assign store    = pix_we & (wr_ptr <  9'(MAX_PIX));
  assign pix_over = pix_we & (wr_ptr == 9'(MAX_PIX));

  // Write bank is always the one not being read
  assign wr_addr = rd_bank ? AW'(wr_ptr) : AW'(MAX_PIX) + AW'(wr_ptr);

  assign rd_in_range = bus.rd_addr < 9'(MAX_PIX);
  assign rd_idx = rd_in_range ?
                  (rd_bank ? AW'(MAX_PIX) + AW'(bus.rd_addr) : AW'(bus.rd_addr)) :
                  '0;

  // Saturating total-line count including any line ending this cycle
  assign line_cnt_next = (hblank_rise && (line_cnt != 9'h1FF)) ? line_cnt + 9'd1 : line_cnt;

  // Write FSM state register
  always_ff @(posedge clk_sys) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Write FSM next-state and pixel/line strobes
  always_comb begin
    state_next = state;
    pix_we     = 1'b0;
    line_end   = 1'b0;
    line_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (pix_ok) begin
          state_next = S_ACTIVE;
          pix_we     = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (hblank_rise) begin
          state_next = S_IDLE;
          line_end   = 1'b1;
          // An empty line leaves the banks and visible-line index alone
          line_done  = (wr_ptr != 9'd0);
        end else if (pix_ok) begin
          pix_we = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Line buffer write port (no reset so it maps onto block RAM)
  always_ff @(posedge clk_sys) begin
    if (store) mem[wr_addr] <= bus.YC;
  end

  // Registered read port; out-of-range addresses return zero
  always_ff @(posedge clk_sys) begin
    if (reset)            rd_data <= 8'd0;
    else if (rd_in_range) rd_data <= mem[rd_idx];
    else                  rd_data <= 8'd0;
  end

  // Line completion, bank swap and frame tracking
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hblank_q    <= 1'b0;
      vsync_q     <= 1'b0;
      wr_ptr      <= 9'd0;
      vis_line    <= 9'd0;
      line_cnt    <= 9'd0;
      seen_vsync  <= 1'b0;
      rd_bank     <= 1'b1;
      line_ready  <= 1'b0;
      line_num    <= 9'd0;
      line_len    <= 9'd0;
      frame_start <= 1'b0;
      pal_detect  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      hblank_q    <= bus.hblank;
      vsync_q     <= bus.vsync;
      line_ready  <= 1'b0;
      frame_start <= 1'b0;
      line_cnt    <= line_cnt_next;

      if (store)    wr_ptr   <= wr_ptr + 9'd1;
      if (pix_over) overflow <= 1'b1;
      if (line_end) wr_ptr   <= 9'd0;

      if (line_done) begin
        rd_bank    <= ~rd_bank;
        line_len   <= wr_ptr;
        line_num   <= vis_line;
        line_ready <= 1'b1;
        vis_line   <= vis_line + 9'd1;
      end

      // Frame reset overrides the line increment when both land together
      if (vsync_rise) begin
        // The partial frame seen straight after reset is not trusted
        if (seen_vsync) pal_detect <= (line_cnt_next >= 9'(PAL_THRESH));
        seen_vsync  <= 1'b1;
        line_cnt    <= 9'd0;
        vis_line    <= 9'd0;
        frame_start <= 1'b1;
      end
    end
  end

`ifdef MARIA_VRX_CRC_EN
  logic [15:0] crc_acc;
  logic [15:0] crc_run;
  logic [15:0] frame_crc;

  // CRC-16-CCITT (poly 0x1021), one byte, MSB first
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  assign crc_run = store ? crc16_byte(crc_acc, bus.YC) : crc_acc;

  // Accumulate over stored pixels, publish and restart at each frame boundary
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      crc_acc   <= 16'hFFFF;
      frame_crc <= 16'h0000;
    end else if (vsync_rise) begin
      frame_crc <= crc_run;
      crc_acc   <= 16'hFFFF;
    end else begin
      crc_acc   <= crc_run;
    end
  end

  assign bus.frame_crc = frame_crc;
`endif

  assign bus.rd_data     = rd_data;
  assign bus.rd_bank     = rd_bank;
  assign bus.line_ready  = line_ready;
  assign bus.line_num    = line_num;
  assign bus.line_len    = line_len;
  assign bus.frame_start = frame_start;
  assign bus.pal_detect  = pal_detect;
  assign bus.overflow    = overflow;

endmodule

`default_nettype wire

// File: tb/tb_maria_video_rx.sv
// ============================================================================
//  Module      : tb_maria_video_rx
//  Description : Directed self-checking bench for maria_video_rx.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_maria_video_rx;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  int   errors  = 0;
  int   checks  = 0;

  maria_video_rx_if bus();

  maria_video_rx #(.MAX_PIX(320), .PAL_THRESH(288)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [8:0] addr;
    logic [7:0] exp;
  } rd_vec_t;

  rd_vec_t tbl [8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // Visible line of n pixels (YC = i*inc+off), ended by an hblank rise
  // optionally coincident with a vsync rise
  task automatic pix_line(input int n, input int inc, input int off, input logic vs);
    bus.hblank = 1'b0;
    bus.vblank = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.YC    = 8'(i * inc + off);
      bus.mclk0 = 1'b1;
      step();
      bus.mclk0 = 1'b0;
      step();
    end
    bus.hblank = 1'b1;
    bus.vsync  = vs;
    step();
  endtask

  task automatic blank_lines(input int n);
    bus.vblank = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.hblank = 1'b0;
      step();
      bus.hblank = 1'b1;
      step();
    end
    bus.vblank = 1'b0;
  endtask

  task automatic vsync_pulse(input string name, input int pal_exp);
    bus.vsync = 1'b1;
    step();
    chk({name, "_frame_start"}, int'(bus.frame_start), 1);
    chk({name, "_pal"}, int'(bus.pal_detect), pal_exp);
    bus.vsync = 1'b0;
    step();
    chk({name, "_frame_start_off"}, int'(bus.frame_start), 0);
  endtask

  function automatic logic [15:0] crc_zeros(input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int k = 0; k < n * 8; k++) begin
      if (c[15]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else       c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  task automatic chk_reset_state(input string name);
    chk({name, "_line_ready"},  int'(bus.line_ready), 0);
    chk({name, "_rd_bank"},     int'(bus.rd_bank), 1);
    chk({name, "_line_num"},    int'(bus.line_num), 0);
    chk({name, "_line_len"},    int'(bus.line_len), 0);
    chk({name, "_frame_start"}, int'(bus.frame_start), 0);
    chk({name, "_pal"},         int'(bus.pal_detect), 0);
    chk({name, "_overflow"},    int'(bus.overflow), 0);
    chk({name, "_rd_data"},     int'(bus.rd_data), 0);
`ifdef MARIA_VRX_CRC_EN
    chk({name, "_frame_crc"},   int'(bus.frame_crc), 0);
`endif
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Read-back table for the third line of test 1 (YC = i + 14)
    tbl[0] = '{9'd0,   8'd14};
    tbl[1] = '{9'd5,   8'd19};
    tbl[2] = '{9'd100, 8'd114};
    tbl[3] = '{9'd241, 8'd255};
    tbl[4] = '{9'd242, 8'd0};
    tbl[5] = '{9'd319, 8'd77};
    tbl[6] = '{9'd320, 8'd0};
    tbl[7] = '{9'd511, 8'd0};

    bus.mclk0   = 1'b0;
    bus.YC      = 8'd0;
    bus.hsync   = 1'b0;
    bus.vsync   = 1'b0;
    bus.hblank  = 1'b1;
    bus.vblank  = 1'b0;
    bus.rd_addr = 9'd0;

    reset = 1'b1;
    step();
    step();
    chk_reset_state("reset");
    reset = 1'b0;
    step();

    // Test 1: three full lines, bank ping-pong, line numbering
    for (int l = 0; l < 3; l++) begin
      pix_line(320, 1, 7 * l, 1'b0);
      chk($sformatf("t1_line_ready_%0d", l), int'(bus.line_ready), 1);
      chk($sformatf("t1_rd_bank_%0d", l),    int'(bus.rd_bank), (l % 2 == 0) ? 0 : 1);
      chk($sformatf("t1_line_num_%0d", l),   int'(bus.line_num), l);
      chk($sformatf("t1_line_len_%0d", l),   int'(bus.line_len), 320);
      step();
      chk($sformatf("t1_line_ready_off_%0d", l), int'(bus.line_ready), 0);
    end
    chk("t1_overflow", int'(bus.overflow), 0);

    for (int i = 0; i < 8; i++) begin
      bus.rd_addr = tbl[i].addr;
      step();
      chk($sformatf("t1_rd_data_addr%0d", tbl[i].addr), int'(bus.rd_data), int'(tbl[i].exp));
    end

    // One-cycle read latency: data follows the address by exactly one edge
    bus.rd_addr = 9'd5;
    step();
    chk("t1_lat_a5", int'(bus.rd_data), 19);
    bus.rd_addr = 9'd100;
    #2;
    chk("t1_lat_hold", int'(bus.rd_data), 19);
    step();
    chk("t1_lat_a100", int'(bus.rd_data), 114);

    // Test 2: overlong line saturates line_len and sets sticky overflow
    pix_line(330, 1, 0, 1'b0);
    chk("t2_line_ready", int'(bus.line_ready), 1);
    chk("t2_line_num",   int'(bus.line_num), 3);
    chk("t2_line_len",   int'(bus.line_len), 320);
    chk("t2_overflow",   int'(bus.overflow), 1);
    bus.rd_addr = 9'd319;
    step();
    chk("t2_rd_last", int'(bus.rd_data), 63);
    pix_line(320, 1, 0, 1'b0);
    chk("t2_line_len_next", int'(bus.line_len), 320);
    chk("t2_overflow_sticky", int'(bus.overflow), 1);
    step();

    // Test 4: vblank pixels ignored; coincident hblank/vsync rise
    vsync_pulse("t4_vs0", 0);
    bus.vblank = 1'b1;
    bus.hblank = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.mclk0 = 1'b1;
      step();
      bus.mclk0 = 1'b0;
      step();
    end
    bus.hblank = 1'b1;
    step();
    chk("t4_vblank_no_line", int'(bus.line_ready), 0);
    bus.vblank = 1'b0;
    for (int l = 0; l < 7; l++) begin
      pix_line(4, 1, 0, 1'b0);
    end
    chk("t4_line_num6", int'(bus.line_num), 6);
    pix_line(4, 1, 0, 1'b1);
    chk("t4_coinc_ready",  int'(bus.line_ready), 1);
    chk("t4_coinc_num",    int'(bus.line_num), 7);
    chk("t4_coinc_len",    int'(bus.line_len), 4);
    chk("t4_coinc_frame",  int'(bus.frame_start), 1);
    bus.vsync = 1'b0;
    step();
    pix_line(4, 1, 0, 1'b0);
    chk("t4_after_num", int'(bus.line_num), 0);
    step();

    // Test 5: reset mid-line discards the partial line
    bus.hblank = 1'b0;
    bus.vblank = 1'b0;
    for (int i = 0; i < 100; i++) begin
      bus.mclk0 = 1'b1;
      step();
      bus.mclk0 = 1'b0;
      step();
    end
    reset = 1'b1;
    bus.hblank = 1'b1;
    step();
    chk_reset_state("t5_reset");
    reset = 1'b0;
    step();
    chk("t5_no_ready", int'(bus.line_ready), 0);
    step();
    chk("t5_no_ready2", int'(bus.line_ready), 0);
    pix_line(320, 1, 0, 1'b0);
    chk("t5_ready",   int'(bus.line_ready), 1);
    chk("t5_num",     int'(bus.line_num), 0);
    chk("t5_len",     int'(bus.line_len), 320);
    chk("t5_rd_bank", int'(bus.rd_bank), 0);
    step();

    // Test 3: PAL detection, first partial frame ignored, saturation
    blank_lines(300);
    vsync_pulse("t3_first", 0);
    blank_lines(263);
    vsync_pulse("t3_263", 0);
    blank_lines(313);
    vsync_pulse("t3_313", 1);
    blank_lines(287);
    vsync_pulse("t3_287", 0);
    blank_lines(288);
    vsync_pulse("t3_288", 1);
    blank_lines(600);
    vsync_pulse("t3_600", 1);
    blank_lines(263);
    vsync_pulse("t3_263b", 0);

`ifdef MARIA_VRX_CRC_EN
    // Test 6: frame CRC of one line of 320 zero pixels
    pix_line(320, 0, 0, 1'b0);
    step();
    vsync_pulse("t6_vs", 0);
    chk("t6_frame_crc", int'(bus.frame_crc), int'(crc_zeros(320)));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
